// File: rtl/conv1d_mem_sched.sv
// conv1d_mem_sched: sequencer/arbiter for the conv1d single-port SRAM (NumWords x 32).
// While idle the host owns the SRAM. A job fetches the kernel words, streams the input
// words to the MAC datapath and writes the returned results back to SRAM.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   start_i                       job start pulse (ignored unless idle)
//   in_base_i, in_len_i           input vector base address / length in words
//   k_base_i, k_len_i             kernel base address / number of taps
//   out_base_i                    output base address
//   ext_gnt_o                     1: host owns SRAM, 0: accelerator owns SRAM
//   mem_req_o, mem_we_o,
//   mem_be_o, mem_addr_o,
//   mem_wdata_o                   internal SRAM request
//   k_valid_o, k_idx_o            SRAM rdata this cycle is kernel tap k_idx_o
//   x_valid_o                     SRAM rdata this cycle is the next input sample
//   res_valid_i, res_data_i       result from the datapath
//   busy_o, done_o, err_o         job status (err_o sticky until the next valid start)
module conv1d_mem_sched #(
  parameter int unsigned NumWords  = 128,
  parameter int unsigned AddrWidth = $clog2(NumWords),
  parameter int unsigned MaxKLen   = 16,
  parameter int unsigned LenWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] in_base_i,
  input  logic [LenWidth-1:0]  in_len_i,
  input  logic [AddrWidth-1:0] k_base_i,
  input  logic [4:0]           k_len_i,
  input  logic [AddrWidth-1:0] out_base_i,
  output logic                 ext_gnt_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic                 k_valid_o,
  output logic [3:0]           k_idx_o,
  output logic                 x_valid_o,
  input  logic                 res_valid_i,
  input  logic [31:0]          res_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {StIdle, StLoadK, StStream, StFlush, StDone} state_e;

  localparam logic [4:0] MaxKLenW = 5'(MaxKLen);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] in_base_q, k_base_q, out_base_q;
  logic [LenWidth-1:0]  in_len_q;
  logic [4:0]           k_len_q;
  logic [4:0]           i_q, i_d;
  logic [LenWidth-1:0]  j_q, j_d;
  logic [LenWidth-1:0]  o_q, o_d;
  logic                 err_q, err_d;
  logic                 k_valid_q, k_valid_d;
  logic [3:0]           k_idx_q, k_idx_d;
  logic                 x_valid_q, x_valid_d;
  logic                 cfg_load;
  logic                 cfg_bad;
  logic [LenWidth-1:0]  n_out;
  logic [LenWidth-1:0]  o_inc;

  assign cfg_bad = (k_len_i == 5'd0) || (k_len_i > MaxKLenW) ||
                   (LenWidth'(k_len_i) > in_len_i);
  assign n_out   = in_len_q - LenWidth'(k_len_q) + LenWidth'(1);
  assign o_inc   = o_q + LenWidth'(1);

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    o_d         = o_q;
    err_d       = err_q;
    k_valid_d   = 1'b0;
    k_idx_d     = k_idx_q;
    x_valid_d   = 1'b0;
    cfg_load    = 1'b0;
    ext_gnt_o   = 1'b1;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cfg_bad) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            cfg_load = 1'b1;
            err_d    = 1'b0;
            i_d      = '0;
            j_d      = '0;
            o_d      = '0;
            state_d  = StLoadK;
          end
        end
      end
      StLoadK: begin
        ext_gnt_o  = 1'b0;
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = k_base_q + AddrWidth'(i_q);
        k_valid_d  = 1'b1;
        k_idx_d    = i_q[3:0];
        i_d        = i_q + 5'd1;
        if (i_q == k_len_q - 5'd1) state_d = StStream;
      end
      StStream: begin
        ext_gnt_o = 1'b0;
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        if (res_valid_i) begin
          // Write-back wins the port; the pending input read retries next cycle.
          mem_we_o    = 1'b1;
          mem_be_o    = 4'hF;
          mem_addr_o  = out_base_q + AddrWidth'(o_q);
          mem_wdata_o = res_data_i;
          o_d         = o_inc;
        end else begin
          mem_addr_o = in_base_q + AddrWidth'(j_q);
          x_valid_d  = 1'b1;
          j_d        = j_q + LenWidth'(1);
          if (j_q == in_len_q - LenWidth'(1)) state_d = StFlush;
        end
      end
      StFlush: begin
        ext_gnt_o = 1'b0;
        busy_o    = 1'b1;
        if (res_valid_i) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_be_o    = 4'hF;
          mem_addr_o  = out_base_q + AddrWidth'(o_q);
          mem_wdata_o = res_data_i;
          o_d         = o_inc;
          if (o_inc == n_out) state_d = StDone;
        end else if (o_q == n_out) begin
          // All results already landed while still streaming.
          state_d = StDone;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      in_base_q  <= '0;
      in_len_q   <= '0;
      k_base_q   <= '0;
      k_len_q    <= '0;
      out_base_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      o_q        <= '0;
      err_q      <= 1'b0;
      k_valid_q  <= 1'b0;
      k_idx_q    <= '0;
      x_valid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      o_q       <= o_d;
      err_q     <= err_d;
      k_valid_q <= k_valid_d;
      k_idx_q   <= k_idx_d;
      x_valid_q <= x_valid_d;
      if (cfg_load) begin
        in_base_q  <= in_base_i;
        in_len_q   <= in_len_i;
        k_base_q   <= k_base_i;
        k_len_q    <= k_len_i;
        out_base_q <= out_base_i;
      end
    end
  end

  assign k_valid_o = k_valid_q;
  assign k_idx_o   = k_idx_q;
  assign x_valid_o = x_valid_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_conv1d_mem_sched.sv
// Randomized self-checking bench for conv1d_mem_sched. A reference model derives the
// expected SRAM transaction order (kernel reads, input reads, result writes) from the job
// configuration; a datapath model returns results only once enough samples have arrived.
module tb_conv1d_mem_sched;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [6:0]  in_base_i = '0, k_base_i = '0, out_base_i = '0;
  logic [7:0]  in_len_i = '0;
  logic [4:0]  k_len_i = '0;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_data_i = '0;
  logic        ext_gnt_o, mem_req_o, mem_we_o, k_valid_o, x_valid_o;
  logic        busy_o, done_o, err_o;
  logic [3:0]  mem_be_o, k_idx_o;
  logic [6:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;

  int checks = 0;
  int errors = 0;

  conv1d_mem_sched dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .in_base_i  (in_base_i),
    .in_len_i   (in_len_i),
    .k_base_i   (k_base_i),
    .k_len_i    (k_len_i),
    .out_base_i (out_base_i),
    .ext_gnt_o  (ext_gnt_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_be_o   (mem_be_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .k_valid_o  (k_valid_o),
    .k_idx_o    (k_idx_o),
    .x_valid_o  (x_valid_o),
    .res_valid_i(res_valid_i),
    .res_data_i (res_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_err);
    chk({tag, "_gnt"}, ext_gnt_o, 1);
    chk({tag, "_req"}, mem_req_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_o, exp_err);
    chk({tag, "_kv"}, k_valid_o, 0);
    chk({tag, "_xv"}, x_valid_o, 0);
  endtask

  task automatic drive_cfg(input int ib, input int il, input int kb, input int kl, input int ob);
    in_base_i  = 7'(ib);
    in_len_i   = 8'(il);
    k_base_i   = 7'(kb);
    k_len_i    = 5'(kl);
    out_base_i = 7'(ob);
  endtask

  // early: inject one result exactly when the 3rd input read would issue.
  // abort_x >= 0: assert reset once that many input reads have been issued.
  task automatic run_job(input int ib, input int il, input int kb, input int kl, input int ob,
                         input bit early, input int abort_x);
    int  n_out;
    int  kr, xr, wr, sent, x_seen, prev_kidx, cyc, avail;
    bit  prev_k, prev_x, rd_k, rd_x, early_done;
    n_out = il - kl + 1;
    kr = 0; xr = 0; wr = 0; sent = 0; x_seen = 0; prev_kidx = 0; cyc = 0;
    prev_k = 0; prev_x = 0; early_done = 0;
    drive_cfg(ib, il, kb, kl, ob);
    start_i = 1'b1;
    #1;
    chk("start_gnt", ext_gnt_o, 1);
    chk("start_req", mem_req_o, 0);
    step();
    start_i = 1'b0;
    while (wr < n_out) begin
      if (abort_x >= 0 && xr == abort_x) begin
        rst_ni = 1'b0;
        res_valid_i = 1'b0;
        step();
        #1;
        check_idle("abort", 0);
        chk("abort_done", done_o, 0);
        rst_ni = 1'b1;
        return;
      end
      rd_k = 0;
      rd_x = 0;
      res_valid_i = 1'b0;
      avail = ((x_seen >= kl) ? (x_seen - kl + 1) : 0) - sent;
      if (sent == n_out - 1 && x_seen < il) avail = 0;
      if (early && !early_done && kr == kl && xr == 2) begin
        res_valid_i = 1'b1;
        early_done = 1;
      end else if (avail > 0 && $urandom_range(1, 0) == 1) begin
        res_valid_i = 1'b1;
      end
      if (res_valid_i) begin
        res_data_i = $urandom;
        sent++;
      end
      #1;
      chk("run_gnt", ext_gnt_o, 0);
      chk("run_busy", busy_o, 1);
      chk("run_done", done_o, 0);
      chk("run_err", err_o, 0);
      chk("k_valid", k_valid_o, prev_k);
      if (prev_k) chk("k_idx", k_idx_o, prev_kidx);
      chk("x_valid", x_valid_o, prev_x);
      if (res_valid_i) begin
        chk("wr_req", mem_req_o, 1);
        chk("wr_we", mem_we_o, 1);
        chk("wr_be", mem_be_o, 4'hF);
        chk("wr_addr", mem_addr_o, (ob + wr) % 128);
        chk("wr_data", mem_wdata_o, res_data_i);
        wr++;
      end else if (kr < kl) begin
        chk("kr_req", mem_req_o, 1);
        chk("kr_we", mem_we_o, 0);
        chk("kr_be", mem_be_o, 0);
        chk("kr_addr", mem_addr_o, (kb + kr) % 128);
        rd_k = 1;
        prev_kidx = kr;
        kr++;
      end else if (xr < il) begin
        chk("xr_req", mem_req_o, 1);
        chk("xr_we", mem_we_o, 0);
        chk("xr_be", mem_be_o, 0);
        chk("xr_addr", mem_addr_o, (ib + xr) % 128);
        rd_x = 1;
        xr++;
      end else begin
        chk("flush_req", mem_req_o, 0);
      end
      if (prev_x) x_seen++;
      prev_k = rd_k;
      prev_x = rd_x;
      step();
      cyc++;
      if (cyc > 3000) begin
        chk("job_timeout", 0, 1);
        res_valid_i = 1'b0;
        return;
      end
    end
    res_valid_i = 1'b0;
    #1;
    chk("end_done", done_o, 1);
    check_idle("end", 0);
    step();
    chk("post_done", done_o, 0);
    check_idle("post", 0);
  endtask

  task automatic run_bad(input int il, input int kl);
    drive_cfg(3, il, 9, kl, 20);
    start_i = 1'b1;
    #1;
    chk("bad_start_req", mem_req_o, 0);
    step();
    start_i = 1'b0;
    #1;
    chk("bad_done", done_o, 1);
    check_idle("bad", 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bad_after_done", done_o, 0);
      check_idle("bad_after", 1);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    chk("rst_done", done_o, 0);
    check_idle("rst", 0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("quiet_gnt", ext_gnt_o, 1);
      chk("quiet_req", mem_req_o, 0);
    end

    run_job(0, 8, 16, 3, 32, 0, -1);
    run_job(0, 8, 16, 3, 32, 1, -1);
    run_job(10, 6, 50, 3, 126, 0, -1);
    run_bad(8, 0);
    run_bad(8, 9);
    run_bad(40, 17);
    run_job(120, 12, 125, 5, 3, 0, -1);
    run_job(0, 8, 16, 3, 32, 0, 3);
    run_job(5, 10, 100, 4, 60, 0, -1);
    for (int t = 0; t < 12; t++) begin
      int kl, il;
      kl = $urandom_range(16, 1);
      il = $urandom_range(kl + 24, kl);
      run_job($urandom_range(127, 0), il, $urandom_range(127, 0), kl,
              $urandom_range(127, 0), 0, -1);
    end
    run_job(0, 16, 0, 16, 100, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
